// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: types and constants shared by the pipeline control block.
//   state_e     - memory-wait FSM encoding (RUN / WAIT / ERR)
//   PC_SEL_NONE - ex_pc_sel value meaning "no control transfer"
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEL_NONE = 2'b00;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: pure combinational decode of the three pipeline conditions.
//   inputs : ID source regs/used flags, EX load/dest/pc_sel/pc4, MEM req/ack
//   lu     : load-use hazard between EX load and ID consumer
//   rd     : control-transfer redirect requested by a live EX instruction
//   mw     : MEM stage waiting on data memory
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_wR_i,
  input  logic [1:0]  ex_pc_sel_i,
  input  logic [31:0] ex_pc4_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        lu,
  output logic        rd,
  output logic        mw
);

  logic ex_live;
  logic rs1_hit;
  logic rs2_hit;

  // pc4 bit 31 marks a killed/bubble slot in EX; such a slot creates no hazard.
  assign ex_live = ~ex_pc4_i[31];
  assign rs1_hit = id_rs1_used_i & (id_rs1_i == ex_wR_i);
  assign rs2_hit = id_rs2_used_i & (id_rs2_i == ex_wR_i);

  assign lu = ex_mem_read_i & (ex_wR_i != 5'd0) & ex_live & (rs1_hit | rs2_hit);
  assign rd = (ex_pc_sel_i != PC_SEL_NONE) & ex_live;
  assign mw = mem_req_i & ~mem_ack_i;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / stall / flush controller.
//   Params : TIMEOUT - max consecutive memory-wait cycles before error
//            CNT_W   - width of saturating statistics counters
//   Inputs : clk, rst_n (async, active low), ID/EX/MEM status (see hazard_detect)
//   Outputs: pc_hold_o, if_id_hold_o, id_ex_stop_o, if_id_flush_o, id_ex_flush_o,
//            freeze_o (combinational, priority MW > RD > LU, ERR forces freeze)
//            mem_err_o (sticky), stall_cnt_o, flush_cnt_o (saturating)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_wR_i,
  input  logic [1:0]       ex_pc_sel_i,
  input  logic [31:0]      ex_pc4_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             id_ex_stop_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic lu;
  logic rd;
  logic mw;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_wR_i       (ex_wR_i),
    .ex_pc_sel_i   (ex_pc_sel_i),
    .ex_pc4_i      (ex_pc4_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .lu            (lu),
    .rd            (rd),
    .mw            (mw)
  );

  state_e            state_reg;
  logic [WCNT_W-1:0] wait_cnt_reg;
  logic              mem_err_reg;
  logic              lu_done_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  logic              err;
  logic              lu_stall;
  logic [WCNT_W:0]   wait_inc;

  assign err = (state_reg == ERR);

  // A load-use stall is issued once per hazard; lu_done_reg remembers that the
  // current hazard already got its bubble. While frozen no stall is issued, so
  // the hazard is picked up again the cycle the freeze releases.
  assign lu_stall = lu & ~freeze_o & ~rd & ~lu_done_reg;

  always_comb begin
    freeze_o      = err | mw;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    id_ex_stop_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (freeze_o) begin
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
    end else if (rd) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (lu_stall) begin
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
      id_ex_stop_o = 1'b1;
    end
  end

  // Count this wait cycle; wait_cnt_reg is 0 in RUN, so this also covers entry.
  assign wait_inc = {1'b0, wait_cnt_reg} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          // An ack in the cycle the count would reach TIMEOUT clears mw, so it wins.
          if (mw) begin
            if (wait_inc >= (WCNT_W + 1)'(TIMEOUT)) begin
              state_reg    <= ERR;
              wait_cnt_reg <= '0;
              mem_err_reg  <= 1'b1;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= wait_inc[WCNT_W-1:0];
            end
          end else begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_done_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      lu_done_reg <= lu & (lu_done_reg | lu_stall);
      if (pc_hold_o && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (if_id_flush_o && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign mem_err_o   = mem_err_reg;
  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (TIMEOUT=4, CNT_W=8).
module tb_pipe_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic             ex_mem_read_i;
  logic [4:0]       ex_wR_i;
  logic [1:0]       ex_pc_sel_i;
  logic [31:0]      ex_pc4_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_hold_o;
  logic             if_id_hold_o;
  logic             id_ex_stop_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             freeze_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_wR_i       (ex_wR_i),
    .ex_pc_sel_i   (ex_pc_sel_i),
    .ex_pc4_i      (ex_pc4_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .pc_hold_o     (pc_hold_o),
    .if_id_hold_o  (if_id_hold_o),
    .id_ex_stop_o  (id_ex_stop_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .freeze_o      (freeze_o),
    .mem_err_o     (mem_err_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_hold, if_id_hold, id_ex_stop, if_id_flush, id_ex_flush, freeze, mem_err}
  function automatic logic [6:0] ctl();
    return {pc_hold_o, if_id_hold_o, id_ex_stop_o, if_id_flush_o, id_ex_flush_o,
            freeze_o, mem_err_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_mem_read_i = 1'b0; ex_wR_i = 5'd0; ex_pc_sel_i = 2'b00; ex_pc4_i = 32'h0000_0004;
    mem_req_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  // Classic load-use: EX loads x5, ID reads x5 through rs1.
  task automatic set_lu();
    ex_mem_read_i = 1'b1; ex_wR_i = 5'd5; ex_pc4_i = 32'h0000_0010;
    id_rs1_i = 5'd5; id_rs1_used_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ctl", 32'(ctl()), 32'h00);
    check("rst_stall", 32'(stall_cnt_o), 32'd0);
    check("rst_flush", 32'(flush_cnt_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load-use: one-cycle stall, then suppressed while the same hazard persists.
    set_lu(); #1;
    check("lu_ctl", 32'(ctl()), 32'h70);
    tick();
    check("lu_stall1", 32'(stall_cnt_o), 32'd1);
    check("lu_once", 32'(ctl()), 32'h00);
    tick();
    check("lu_stall_keep", 32'(stall_cnt_o), 32'd1);
    idle(); tick();

    // No hazard for x0 destination, for a bubble slot, or for an unused rs1.
    set_lu(); ex_wR_i = 5'd0; id_rs1_i = 5'd0; #1;
    check("lu_x0", 32'(ctl()), 32'h00);
    set_lu(); ex_pc4_i = 32'h8000_0010; #1;
    check("lu_bubble", 32'(ctl()), 32'h00);
    set_lu(); id_rs1_used_i = 1'b0; #1;
    check("lu_unused", 32'(ctl()), 32'h00);
    id_rs2_i = 5'd5; id_rs2_used_i = 1'b1; #1;
    check("lu_rs2", 32'(ctl()), 32'h70);
    tick();
    check("lu_stall2", 32'(stall_cnt_o), 32'd2);
    idle(); tick();

    // Redirect beats load-use; a bubble slot's redirect is ignored.
    set_lu(); ex_pc_sel_i = 2'b01; #1;
    check("rd_ctl", 32'(ctl()), 32'h0C);
    tick();
    check("rd_flush1", 32'(flush_cnt_o), 32'd1);
    ex_pc4_i = 32'h8000_0010; #1;
    check("rd_bubble", 32'(ctl()), 32'h00);
    idle(); tick();

    // Memory wait for 3 cycles with a load-use pending; ack arrives on the
    // cycle the wait count would reach TIMEOUT, so no error. The pending LU
    // is issued in the ack cycle when the freeze releases.
    set_lu(); mem_req_i = 1'b1; #1;
    check("mw_c1", 32'(ctl()), 32'h62);
    tick();
    check("mw_c2", 32'(ctl()), 32'h62);
    tick();
    check("mw_c3", 32'(ctl()), 32'h62);
    tick();
    mem_ack_i = 1'b1; #1;
    check("mw_ack_lu", 32'(ctl()), 32'h70);
    tick();
    check("mw_stall", 32'(stall_cnt_o), 32'd6);
    check("mw_no_err", 32'(mem_err_o), 32'd0);
    idle(); tick();

    // Timeout: 4 wait cycles without ack -> sticky error.
    mem_req_i = 1'b1;
    tick(); tick(); tick();
    check("to_before", 32'(mem_err_o), 32'd0);
    tick();
    check("to_err", 32'(mem_err_o), 32'd1);
    check("to_stall", 32'(stall_cnt_o), 32'd10);
    mem_req_i = 1'b0; #1;
    check("err_ctl", 32'(ctl()), 32'h63);

    // Stay in ERR past counter capacity: stall_cnt must stick at all-ones.
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    check("sat_stall", 32'(stall_cnt_o), 32'hFF);
    check("err_sticky", 32'(ctl()), 32'h63);

    // Asynchronous reset mid-cycle clears everything.
    #2 rst_n = 1'b0; #1;
    check("ar_ctl", 32'(ctl()), 32'h00);
    check("ar_stall", 32'(stall_cnt_o), 32'd0);
    check("ar_flush", 32'(flush_cnt_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    set_lu(); #1;
    check("post_rst_lu", 32'(ctl()), 32'h70);
    tick();
    check("post_rst_st", 32'(stall_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max consecutive memory-wait cycles before error.
REQ-002 Parameter CNT_W, default 16: width of statistics counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs1_i, id_rs2_i  in  5 each  source register indices of the instruction in ID.
REQ-006 id_rs1_used_i, id_rs2_used_i  in  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_mem_read_i  in  1  EX instruction is a load.
REQ-008 ex_wR_i  in  5  EX destination register.
REQ-009 ex_pc_sel_i  in  2  EX control-transfer select; nonzero means redirect requested.
REQ-010 ex_pc4_i  in  32  EX pc+4; bit 31 set marks a discarded/bubble slot.
REQ-011 mem_req_i  in  1  MEM stage has an outstanding data-memory access.
REQ-012 mem_ack_i  in  1  data memory completes the access this cycle.
REQ-013 pc_hold_o  out  1  PC keeps its value.
REQ-014 if_id_hold_o  out  1  IF/ID register keeps its value.
REQ-015 id_ex_stop_o  out  1  ID/EX inserts a bubble (its pipeline-stop input).
REQ-016 if_id_flush_o, id_ex_flush_o  out  1 each  force pc4 bit 31 into IF/ID and ID/EX (kill slot).
REQ-017 freeze_o  out  1  all pipeline registers from PC through MEM/WB hold.
REQ-018 mem_err_o  out  1  sticky memory-timeout error.
REQ-019 stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating statistics.

Function
REQ-020 Load-use hazard (LU) = ex_mem_read_i & ex_wR_i!=0 & ~ex_pc4_i[31] & ((id_rs1_used_i & id_rs1_i==ex_wR_i) | (id_rs2_used_i & id_rs2_i==ex_wR_i)).
REQ-021 Redirect (RD) = ex_pc_sel_i!=0 & ~ex_pc4_i[31].
REQ-022 Memory wait (MW) = mem_req_i & ~mem_ack_i.
REQ-023 Control outputs pc_hold_o, if_id_hold_o, id_ex_stop_o, flush outputs, freeze_o are combinational, same-cycle (zero latency).
REQ-024 Priority: MW > RD > LU; only the highest active condition drives outputs.
REQ-025 MW: freeze_o=1, pc_hold_o=1, if_id_hold_o=1; all other controls 0.
REQ-026 RD: if_id_flush_o=1, id_ex_flush_o=1; holds and id_ex_stop_o 0.
REQ-027 LU: pc_hold_o=1, if_id_hold_o=1, id_ex_stop_o=1 for exactly one cycle per hazard; no flush.
REQ-028 None active: all control outputs 0.
REQ-029 FSM states RUN, WAIT, ERR (registered); RUN->WAIT when MW; WAIT->RUN when mem_ack_i or ~mem_req_i; WAIT->ERR when wait counter reaches TIMEOUT; ERR exits only by reset.
REQ-030 Wait counter (8 bits min, sized for TIMEOUT) increments each MW cycle, clears on leaving WAIT; mem_ack_i in the same cycle the counter would hit TIMEOUT wins (no error).
REQ-031 ERR: mem_err_o=1, freeze_o=1, pc_hold_o=1, if_id_hold_o=1 permanently.
REQ-032 stall_cnt_o increments each cycle pc_hold_o=1; flush_cnt_o increments each cycle if_id_flush_o=1; both saturate at all-ones, never wrap.
REQ-033 LU suppressed while freeze_o=1; re-evaluated the cycle freeze releases.

Reset
REQ-034 rst_n low asynchronously forces state RUN, wait counter 0, mem_err_o 0, stall_cnt_o 0, flush_cnt_o 0; combinational outputs follow from inputs with state RUN.
REQ-035 Reset mid-WAIT or in ERR returns to RUN with no residual error.

Structure
REQ-036 State encoding (RUN, WAIT, ERR) and pc_sel "no jump" constant 2'b00 reside in the shared CPU package.
REQ-037 One sub-module hazard_detect (pure combinational LU/RD/MW decode); counters and FSM stay in pipe_ctrl.

Verification
REQ-038 ex_mem_read=1, ex_wR=5, id_rs1=5 used, pc4[31]=0 -> pc_hold, if_id_hold, id_ex_stop =1 one cycle; stall_cnt 0->1.
REQ-039 Same as 038 but ex_wR=0 or pc4[31]=1 -> all controls 0.
REQ-040 ex_pc_sel=2'b01 with LU also true -> only if_id_flush, id_ex_flush =1; flush_cnt +1.
REQ-041 mem_req=1, ack after 3 cycles -> freeze_o=1 for 3 cycles, drop in ack cycle; stall_cnt +3.
REQ-042 TIMEOUT=4, mem_req held, no ack -> mem_err_o=1 after 4 wait cycles, sticky; rst_n pulse clears all.
REQ-043 Force 2^CNT_W+5 hold cycles -> stall_cnt_o stays all-ones.
